// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regfile_state_e;

    localparam int DATA_W_DEF   = 64;
    localparam int NUM_REGS_DEF = 32;
    localparam int ZERO_REG_DEF = 31;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every register index once, then raises ready.
// Also tracks the sticky write-dropped flag for writes requested before ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS_DEF)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              reg_wr,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              wr_dropped
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    regfile_state_e    state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              wr_dropped_q, wr_dropped_d;

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        clr_idx_q    <= clr_idx_d;
        wr_dropped_q <= wr_dropped_d;
    end

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        wr_dropped_d = wr_dropped_q;
        clr_we       = 1'b0;
        if (srst) begin
            state_d      = CLEAR;
            clr_idx_d    = '0;
            wr_dropped_d = 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_we    = 1'b1;
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                    if (clr_idx_q == LAST_IDX) begin
                        state_d   = RUN;
                        clr_idx_d = '0;
                    end
                    if (reg_wr) begin
                        wr_dropped_d = 1'b1;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            endcase
        end
    end

    assign ready      = (state_q == RUN);
    assign clr_idx    = clr_idx_q;
    assign wr_dropped = wr_dropped_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with a hard-zero index and a
// post-reset clear sequence. Define REGFILE_BYPASS_EN to forward BusW to reads.
module reg_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RW,
    input  logic              RegWr,
    input  logic [DATA_W-1:0] BusW,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic              Ready,
    output logic              WrDropped
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              ready;
    logic              user_wr;

    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    regfile_clear_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clear_seq (
        .clk        (Clk),
        .srst       (Reset),
        .reg_wr     (RegWr),
        .ready      (ready),
        .clr_we     (clr_we),
        .clr_idx    (clr_idx),
        .wr_dropped (WrDropped)
    );

    // Reset wins over a same-cycle write; the array is about to be cleared anyway.
    assign user_wr = ready && !Reset && RegWr && (RW != ZERO_ADDR);

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = RW;
        wr_data_d = BusW;
        if (clr_we) begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_idx;
            wr_data_d = '0;
        end else if (user_wr) begin
            wr_en_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    assign rd_addr[0] = RA;
    assign rd_addr[1] = RB;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] data;
            always_comb begin
                data = '0;
                if (ready && (rd_addr[gi] != ZERO_ADDR)) begin
                    data = regs_q[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                    if (user_wr && (RW == rd_addr[gi])) begin
                        data = BusW;
                    end
`endif
                end
            end
            assign rd_data[gi] = data;
        end
    endgenerate

    assign BusA  = rd_data[0];
    assign BusB  = rd_data[1];
    assign Ready = ready;

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: clear sequencing, table-driven RUN
// traffic, hard-zero register, dropped writes, mid-clear reset and read-during-write.
module tb_reg_file_param;

    logic        Clk;
    logic        Reset;
    logic [4:0]  RA, RB, RW;
    logic        RegWr;
    logic [63:0] BusW;
    logic [63:0] BusA, BusB;
    logic        Ready;
    logic        WrDropped;

    int n_total;
    int n_pass;

    typedef struct {
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic        wr;
        logic [63:0] w;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;

    vec_t vecs [8];

    reg_file_param dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RA        (RA),
        .RB        (RB),
        .RW        (RW),
        .RegWr     (RegWr),
        .BusW      (BusW),
        .BusA      (BusA),
        .BusB      (BusB),
        .Ready     (Ready),
        .WrDropped (WrDropped)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                         input logic wr, input logic [63:0] w);
        RA    = ra;
        RB    = rb;
        RW    = rw;
        RegWr = wr;
        BusW  = w;
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 64'd0);
        step();
        Reset = 1'b0;
    endtask

    // Called on cycle 1 after reset release: Ready low for 32 cycles, high on 33.
    task automatic wait_clear(input string tag);
        for (int c = 1; c <= 32; c++) begin
            drive(5'(c - 1), 5'(32 - c), 5'd0, 1'b0, 64'd0);
            #1;
            chk($sformatf("%s ready_low c%0d", tag, c), {63'd0, Ready}, 64'd0);
            chk($sformatf("%s busa_zero c%0d", tag, c), BusA, 64'd0);
            chk($sformatf("%s busb_zero c%0d", tag, c), BusB, 64'd0);
            step();
        end
        #1;
        chk($sformatf("%s ready_high c33", tag), {63'd0, Ready}, 64'd1);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        Reset   = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 64'd0);

        vecs[0] = '{5'd0,  5'd1,  5'd5,  1'b1, 64'hDEADBEEF_0000_0001, 64'd0, 64'd0};
        vecs[1] = '{5'd5,  5'd5,  5'd0,  1'b0, 64'd0, 64'hDEADBEEF_0000_0001, 64'hDEADBEEF_0000_0001};
        vecs[2] = '{5'd5,  5'd31, 5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEADBEEF_0000_0001, 64'd0};
        vecs[3] = '{5'd31, 5'd31, 5'd0,  1'b0, 64'd0, 64'd0, 64'd0};
        vecs[4] = '{5'd3,  5'd5,  5'd2,  1'b1, 64'h0123_4567_89AB_CDEF, 64'd0, 64'hDEADBEEF_0000_0001};
        vecs[5] = '{5'd2,  5'd0,  5'd0,  1'b1, 64'h55, 64'h0123_4567_89AB_CDEF, 64'd0};
        vecs[6] = '{5'd2,  5'd2,  5'd30, 1'b0, 64'hAA, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        vecs[7] = '{5'd0,  5'd31, 5'd0,  1'b0, 64'd0, 64'h55, 64'd0};

        @(negedge Clk);

        // Reset release and full clear timing
        do_reset();
        #1;
        chk("reset wrdropped", {63'd0, WrDropped}, 64'd0);
        wait_clear("clr1");

        // Table-driven RUN traffic
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].ra, vecs[i].rb, vecs[i].rw, vecs[i].wr, vecs[i].w);
            #1;
            chk($sformatf("vec%0d busa", i), BusA, vecs[i].exp_a);
            chk($sformatf("vec%0d busb", i), BusB, vecs[i].exp_b);
            chk($sformatf("vec%0d ready", i), {63'd0, Ready}, 64'd1);
            chk($sformatf("vec%0d wrdropped", i), {63'd0, WrDropped}, 64'd0);
            step();
        end

        // Read-during-write on the same address
        drive(5'd7, 5'd0, 5'd7, 1'b1, 64'h1111);
        step();
        drive(5'd7, 5'd7, 5'd7, 1'b1, 64'h1234);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw busa same cycle", BusA, 64'h1234);
        chk("rdw busb same cycle", BusB, 64'h1234);
`else
        chk("rdw busa same cycle", BusA, 64'h1111);
        chk("rdw busb same cycle", BusB, 64'h1111);
`endif
        step();
        drive(5'd7, 5'd0, 5'd0, 1'b0, 64'd0);
        #1;
        chk("rdw busa next cycle", BusA, 64'h1234);
        drive(5'd31, 5'd31, 5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        chk("zero reg busa during write", BusA, 64'd0);
        step();
        drive(5'd31, 5'd7, 5'd0, 1'b0, 64'd0);
        #1;
        chk("zero reg busa after write", BusA, 64'd0);
        chk("zero write wrdropped", {63'd0, WrDropped}, 64'd0);

        // Write during clear is dropped and flagged
        do_reset();
        for (int c = 1; c <= 32; c++) begin
            if (c == 10) drive(5'd3, 5'd0, 5'd3, 1'b1, 64'd7);
            else         drive(5'd3, 5'd0, 5'd0, 1'b0, 64'd0);
            #1;
            chk($sformatf("drop wrdropped c%0d", c), {63'd0, WrDropped}, (c > 10) ? 64'd1 : 64'd0);
            step();
        end
        drive(5'd3, 5'd3, 5'd0, 1'b0, 64'd0);
        #1;
        chk("drop ready", {63'd0, Ready}, 64'd1);
        chk("drop wrdropped sticky", {63'd0, WrDropped}, 64'd1);
        chk("drop reg3 busa", BusA, 64'd0);

        // Reset mid-clear restarts the full sequence
        drive(5'd0, 5'd0, 5'd4, 1'b1, 64'd9);
        step();
        drive(5'd0, 5'd0, 5'd20, 1'b1, 64'd9);
        step();
        drive(5'd4, 5'd20, 5'd0, 1'b0, 64'd0);
        #1;
        chk("pre-reset reg4", BusA, 64'd9);
        chk("pre-reset reg20", BusB, 64'd9);
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            step();
        end
        #1;
        chk("mid-clear ready c15", {63'd0, Ready}, 64'd0);
        do_reset();
        #1;
        chk("restart wrdropped", {63'd0, WrDropped}, 64'd0);
        wait_clear("clr2");
        drive(5'd4, 5'd20, 5'd0, 1'b0, 64'd0);
        #1;
        chk("restart reg4", BusA, 64'd0);
        chk("restart reg20", BusB, 64'd0);
        chk("restart wrdropped run", {63'd0, WrDropped}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
